// File: rtl/shift_pkg.sv
// Shared encodings for the shift sequencer: datapath register modes and FSM state codes.
// Pure type/constant package; no logic, no latency, no flow control.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/shift_datapath.sv
// Mode-controlled load / right-shift / hold register with a sticky shifted-out-one flag.
// Updates on every clk edge per mode; no handshake, the sequencer owns all pacing.
module shift_datapath
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_value,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             seen_one
);

    logic [WIDTH-1:0] cell_q;
    logic [WIDTH:0]   shift_chain;
    logic             seen_q;

    // Each cell shifts in from its left neighbour; the top cell takes serial_in.
    assign shift_chain = {serial_in, cell_q};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cell_q[i] <= 1'b0;
            end else begin
                case (mode)
                    MODE_LOAD:  cell_q[i] <= load_value[i];
                    MODE_SHIFT: cell_q[i] <= shift_chain[i+1];
                    default:    cell_q[i] <= cell_q[i];
                endcase
            end
        end
    end

    // Reserved mode 2'b11 falls into HOLD along with MODE_HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
        end else begin
            case (mode)
                MODE_LOAD:  seen_q <= 1'b0;
                MODE_SHIFT: seen_q <= seen_q | cell_q[0];
                default:    seen_q <= seen_q;
            endcase
        end
    end

    assign data_out   = cell_q;
    assign serial_out = cell_q[0];
    assign seen_one   = seen_q;

endmodule

// File: rtl/shift_sequencer.sv
// Load-then-shift sequencer: one start yields done N+2 cycles later (N = captured count).
// start is only sampled in IDLE; requests while busy or done are dropped, never queued.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_value,
    input  logic [CNT_W-1:0] shift_count,
    input  logic             serial_in,
    output logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             serial_out,
    output logic             seen_one
);

    state_e           state;
    mode_e            mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    // mode/busy/done are registered alongside the state so they are clean Moore outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mode_q <= MODE_HOLD;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q  <= shift_count;
                        state  <= ST_LOAD;
                        mode_q <= MODE_LOAD;
                        busy_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (cnt_q != '0) begin
                        state  <= ST_SHIFT;
                        mode_q <= MODE_SHIFT;
                    end else begin
                        state  <= ST_DONE;
                        mode_q <= MODE_HOLD;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // Only entered with a nonzero count, so the decrement cannot wrap.
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state  <= ST_DONE;
                        mode_q <= MODE_HOLD;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    mode_q <= MODE_HOLD;
                end
                default: begin
                    state  <= ST_IDLE;
                    mode_q <= MODE_HOLD;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign mode = mode_q;
    assign busy = busy_q;
    assign done = done_q;

    shift_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode_q),
        .load_value (load_value),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .serial_out (serial_out),
        .seen_one   (seen_one)
    );

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer against a queue-based behavioural model.
module tb_shift_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] load_value;
    logic [3:0] shift_count;
    logic       serial_in;
    logic [1:0] mode;
    logic       busy;
    logic       done;
    logic [7:0] data_out;
    logic       serial_out;
    logic       seen_one;

    int n_chk  = 0;
    int n_fail = 0;

    shift_sequencer #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .load_value  (load_value),
        .shift_count (shift_count),
        .serial_in   (serial_in),
        .mode        (mode),
        .busy        (busy),
        .done        (done),
        .data_out    (data_out),
        .serial_out  (serial_out),
        .seen_one    (seen_one)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mode"}, 32'(mode), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_data"}, 32'(data_out), 32'd0);
        check({tag, "_sout"}, 32'(serial_out), 32'd0);
        check({tag, "_seen"}, 32'(seen_one), 32'd0);
    endtask

    // One operation. Caller invokes it away from a rising edge with the DUT idle.
    // smode: 0 random serial_in, 1 all zeros, 2 all ones. noise: random start pulses while active.
    // exp_dat / exp_seen: directed constants, or -1 to rely on the model only.
    task automatic run_op(input logic [7:0] lv, input int n, input int smode, input bit noise,
                          input int exp_dat, input int exp_seen);
        bit          q[$];
        logic [7:0]  r;
        logic        s;
        logic [31:0] rnd;
        bit          sb;
        int          busy_n = 0;
        int          done_n = 0;
        int          done_at = -1;

        rnd = $urandom;
        start       = 1'b1;
        shift_count = 4'(n);
        load_value  = rnd[7:0];
        serial_in   = rnd[8];
        @(posedge clk);
        for (int c = 1; c <= n + 4; c++) begin
            #1;
            // Expected cycle map after the start edge: 1 LOAD, 2..n+1 SHIFT, n+2 DONE, then IDLE.
            if (busy) busy_n++;
            if (c == 1)
                check("mode_load", 32'(mode), 32'd2);
            else if (c <= n + 1)
                check("mode_shift", 32'(mode), 32'd1);
            else
                check("mode_hold", 32'(mode), 32'd0);
            if (done) begin
                done_n++;
                done_at = c;
                r = lv;
                s = 1'b0;
                foreach (q[i]) begin
                    s = s | r[0];
                    r = {q[i], r[7:1]};
                end
                check("done_data", 32'(data_out), 32'(r));
                check("done_seen", 32'(seen_one), 32'(s));
                check("done_sout", 32'(serial_out), 32'(r[0]));
            end
            rnd = $urandom;
            start       = (noise && c <= n + 2) ? rnd[0] : 1'b0;
            shift_count = rnd[4:1];
            load_value  = (c == 1) ? lv : rnd[12:5];
            sb = (smode == 0) ? rnd[13] : (smode == 2);
            serial_in = sb;
            if (c >= 2 && c <= n + 1) q.push_back(sb);
            @(posedge clk);
        end
        #1;
        check("done_pulses", 32'(done_n), 32'd1);
        check("done_latency", 32'(done_at), 32'(n + 2));
        check("busy_cycles", 32'(busy_n), 32'(n + 1));
        check("idle_busy", 32'(busy), 32'd0);
        if (exp_dat >= 0) check("hold_data", 32'(data_out), 32'(exp_dat));
        if (exp_seen >= 0) check("hold_seen", 32'(seen_one), 32'(exp_seen));
    endtask

    initial begin
        logic [31:0] rnd;
        rst_n       = 1'b0;
        start       = 1'b0;
        load_value  = 8'h5A;
        shift_count = 4'd7;
        serial_in   = 1'b1;
        #12;
        check_reset_outputs("reset");

        // First start accepted on the first rising edge after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'hA5, 3, 1, 1'b0, 8'h14, 1);
        @(negedge clk);
        run_op(8'h3C, 0, 0, 1'b0, 8'h3C, 0);
        @(negedge clk);
        run_op(8'h00, 10, 2, 1'b0, 8'hFF, 1);
        @(negedge clk);
        run_op(8'hC3, 6, 0, 1'b1, -1, -1);
        @(negedge clk);
        run_op(8'h81, 15, 0, 1'b1, -1, -1);

        // Abort in the middle of a shift sequence.
        @(negedge clk);
        start       = 1'b1;
        load_value  = 8'hA5;
        shift_count = 4'd5;
        serial_in   = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_pre_mode", 32'(mode), 32'd1);
        check("abort_pre_seen", 32'(seen_one), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 check("abort_no_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h5A, 2, 0, 1'b0, -1, -1);

        for (int k = 0; k < 25; k++) begin
            rnd = $urandom;
            @(negedge clk);
            run_op(rnd[7:0], int'(rnd[11:8]), int'(rnd[13:12] % 3), rnd[14], -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits.
REQ-002 SHALL have parameter CNT_W, default 4, width of the shift-count field.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request to begin one load-then-shift operation; sampled only in IDLE.
REQ-006 load_value  input  WIDTH  parallel value loaded into the register.
REQ-007 shift_count  input  CNT_W  number of right shifts to perform after the load.
REQ-008 serial_in  input  1  bit shifted into the MSB on each shift.
REQ-009 mode  output  2  current register mode {ch1,ch0} driven to the datapath.
REQ-010 busy  output  1  high in the LOAD and SHIFT states.
REQ-011 done  output  1  one-cycle pulse when the operation completes.
REQ-012 data_out  output  WIDTH  current register contents.
REQ-013 serial_out  output  1  register bit 0.
REQ-014 seen_one  output  1  sticky OR of every bit shifted out since the last load.

Function
REQ-015 Mode encoding SHALL be HOLD=2'b00, SHIFT=2'b01, LOAD=2'b10; 2'b11 is reserved, never driven, and the datapath treats it as HOLD.
REQ-016 FSM states SHALL be IDLE, LOAD, SHIFT and DONE; mode is a registered Moore output of the state.
REQ-017 IDLE: mode=HOLD; if start=1 at edge k, shift_count is captured into the down-counter and the state becomes LOAD at edge k.
REQ-018 LOAD (one cycle): mode=LOAD; at the next edge register<=load_value and seen_one<=0; the next state is SHIFT if the captured count is nonzero, else DONE.
REQ-019 SHIFT: mode=SHIFT; at each edge register<={serial_in, register[WIDTH-1:1]}, seen_one<=seen_one|register[0], counter decrements; it leaves for DONE at the edge where the counter reaches 0.
REQ-020 DONE (one cycle): mode=HOLD, done=1, busy=0; the next state is IDLE unconditionally.
REQ-021 Total latency SHALL be N+2 cycles from the start edge to the done cycle (N = captured count); busy is high for exactly N+1 cycles.
REQ-022 start while busy or in DONE SHALL be ignored; no queuing.
REQ-023 load_value and shift_count changes after the start edge SHALL have no effect on the current operation; load_value is sampled at the LOAD-exit edge.
REQ-024 A count greater than WIDTH SHALL be legal; shifts beyond WIDTH fill the register entirely with serial_in history.
REQ-025 In HOLD the register and seen_one SHALL retain their values.
REQ-026 The counter SHALL never underflow; count 0 bypasses SHIFT.

Reset
REQ-027 While rst_n=0: state=IDLE, register=0, counter=0, seen_one=0, mode=HOLD, busy=0, done=0, data_out=0, serial_out=0.
REQ-028 Reset asserted mid-operation SHALL abort immediately with no done pulse; the first start is accepted at the first rising edge after rst_n returns high.

Structure
REQ-029 Mode encodings and FSM state codes SHALL live in a shared package, shift_pkg.
REQ-030 The register SHALL be a sub-module, shift_datapath (WIDTH cells, each a mode-controlled load/shift/hold cell plus OR-chain flag); shift_sequencer holds the FSM and counter.

Verification
REQ-031 Reset: rst_n=0 -> all outputs 0, mode=00.
REQ-032 start, load_value=8'hA5, count=3, serial_in=0 -> data_out=8'h14, seen_one=1, done in cycle 5 after start.
REQ-033 start, load_value=8'h3C, count=0 -> data_out=8'h3C, seen_one=0, done 2 cycles after start, SHIFT never entered.
REQ-034 start, load_value=8'h00, count=10, serial_in=1 -> data_out=8'hFF, seen_one=1, busy for 11 cycles.
REQ-035 start pulsed during SHIFT -> ignored; exactly one done pulse; the next start is accepted from IDLE.
REQ-036 rst_n low during SHIFT of an 8'hA5 count=5 operation -> immediate IDLE, data_out=0, no done pulse.
